// File: rtl/alu_operand_stage.sv
// ID->EX operand stage: registers decoded operands, muxes ALU a/b from registers, forwards writeback results.
// Define ALU_OPSTAGE_SKID_EN for a second (skid) entry with a registered o_ready.
module alu_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [XLEN-1:0]       i_pc,
  input  logic [XLEN-1:0]       i_rs1_data,
  input  logic [XLEN-1:0]       i_rs2_data,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic [XLEN-1:0]       i_imm,
  input  logic                  i_sel_a,
  input  logic                  i_sel_b,
  input  logic [3:0]            i_alu_op,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_fwd_we,
  input  logic [REG_ADDR_W-1:0] i_fwd_rd,
  input  logic [XLEN-1:0]       i_fwd_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [XLEN-1:0]       o_input_a,
  output logic [XLEN-1:0]       o_input_b,
  output logic [3:0]            o_alu_op,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]       o_rs2_data
);

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1;
    logic [XLEN-1:0]       rs2;
    logic [XLEN-1:0]       imm;
    logic                  sel_a;
    logic                  sel_b;
    logic [3:0]            op;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
  } entry_t;

  // x0 is hardwired zero, so a write to index 0 never forwards.
  function automatic logic fwd_hit(input logic we, input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] addr);
    return we && (rd != '0) && (rd == addr);
  endfunction

  function automatic entry_t fwd_upd(input entry_t e, input logic we,
                                     input logic [REG_ADDR_W-1:0] rd, input logic [XLEN-1:0] data);
    entry_t r;
    r = e;
    if (fwd_hit(we, rd, e.rs1_addr)) r.rs1 = data;
    if (fwd_hit(we, rd, e.rs2_addr)) r.rs2 = data;
    return r;
  endfunction

  entry_t out_q, in_ent, out_fwd;
  logic   out_vld;
  logic   accept, out_xfer;

  always_comb begin
    in_ent          = '0;
    in_ent.pc       = i_pc;
    in_ent.rs1      = i_rs1_data;
    in_ent.rs2      = i_rs2_data;
    in_ent.imm      = i_imm;
    in_ent.sel_a    = i_sel_a;
    in_ent.sel_b    = i_sel_b;
    in_ent.op       = i_alu_op;
    in_ent.rd       = i_rd_addr;
    in_ent.rs1_addr = i_rs1_addr;
    in_ent.rs2_addr = i_rs2_addr;
    in_ent          = fwd_upd(in_ent, i_fwd_we, i_fwd_rd, i_fwd_data);
  end

  assign out_fwd  = fwd_upd(out_q, i_fwd_we, i_fwd_rd, i_fwd_data);
  assign out_xfer = out_vld & i_ready;
  assign accept   = i_valid & o_ready & ~i_flush;

`ifdef ALU_OPSTAGE_SKID_EN
  entry_t skid_q, skid_fwd;
  logic   skid_vld;

  assign skid_fwd = fwd_upd(skid_q, i_fwd_we, i_fwd_rd, i_fwd_data);
  assign o_ready  = ~skid_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q    <= '0;
      out_vld  <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
    end else if (i_flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!out_vld || out_xfer) begin
      // Output slot frees this edge: skid entry (older) has priority over the incoming one.
      if (skid_vld) begin
        out_q    <= skid_fwd;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else if (accept) begin
        out_q   <= in_ent;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else begin
      out_q <= out_fwd;
      if (accept) begin
        skid_q   <= in_ent;
        skid_vld <= 1'b1;
      end else begin
        skid_q <= skid_fwd;
      end
    end
  end
`else
  assign o_ready = ~out_vld | i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q   <= '0;
      out_vld <= 1'b0;
    end else if (i_flush) begin
      out_vld <= 1'b0;
    end else if (accept) begin
      out_q   <= in_ent;
      out_vld <= 1'b1;
    end else begin
      out_q <= out_fwd;
      if (out_xfer) out_vld <= 1'b0;
    end
  end
`endif

  assign o_valid    = out_vld;
  assign o_input_a  = out_q.sel_a ? out_q.pc  : out_q.rs1;
  assign o_input_b  = out_q.sel_b ? out_q.imm : out_q.rs2;
  assign o_alu_op   = out_q.op;
  assign o_rd_addr  = out_q.rd;
  assign o_rs2_data = out_q.rs2;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; skid checks compile in when ALU_OPSTAGE_SKID_EN is defined.
module tb_alu_operand_stage;
  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
  logic [31:0] i_pc = '0, i_rs1_data = '0, i_rs2_data = '0, i_imm = '0, i_fwd_data = '0;
  logic [4:0]  i_rs1_addr = '0, i_rs2_addr = '0, i_rd_addr = '0, i_fwd_rd = '0;
  logic        i_sel_a = 1'b0, i_sel_b = 1'b0, i_fwd_we = 1'b0;
  logic [3:0]  i_alu_op = '0;
  logic        o_ready, o_valid;
  logic [31:0] o_input_a, o_input_b, o_rs2_data;
  logic [3:0]  o_alu_op;
  logic [4:0]  o_rd_addr;
  int          n_chk = 0, n_pass = 0;

  alu_operand_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_rs1_addr(i_rs1_addr),
    .i_rs2_addr(i_rs2_addr), .i_imm(i_imm), .i_sel_a(i_sel_a), .i_sel_b(i_sel_b),
    .i_alu_op(i_alu_op), .i_rd_addr(i_rd_addr), .i_fwd_we(i_fwd_we), .i_fwd_rd(i_fwd_rd),
    .i_fwd_data(i_fwd_data), .o_valid(o_valid), .i_ready(i_ready), .o_input_a(o_input_a),
    .o_input_b(o_input_b), .o_alu_op(o_alu_op), .o_rd_addr(o_rd_addr), .o_rs2_data(o_rs2_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, rs1, rs2, imm, input logic [4:0] a1, a2, rd,
                       input logic sa, sb, input logic [3:0] op);
    i_valid = 1'b1; i_pc = pc; i_rs1_data = rs1; i_rs2_data = rs2; i_imm = imm;
    i_rs1_addr = a1; i_rs2_addr = a2; i_rd_addr = rd; i_sel_a = sa; i_sel_b = sb; i_alu_op = op;
  endtask

  initial begin
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_a", o_input_a, 32'd0);
    chk("rst_b", o_input_b, 32'd0);
    step();
    i_rst_n = 1'b1;
    i_ready = 1'b1;

    // rs1=5, imm=7, sel_b=1
    drive(32'h100, 32'd5, 32'd9, 32'd7, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1, 4'd0);
    step();
    chk("t2_valid", {31'd0, o_valid}, 32'd1);
    chk("t2_a", o_input_a, 32'd5);
    chk("t2_b", o_input_b, 32'd7);
    chk("t2_op", {28'd0, o_alu_op}, 32'd0);
    chk("t2_rs2", o_rs2_data, 32'd9);

    // capture-time forward into rs1; back-to-back transfer-and-accept
    drive(32'h104, 32'h11, 32'h12, 32'd0, 5'd3, 5'd2, 5'd5, 1'b0, 1'b0, 4'd1);
    i_fwd_we = 1'b1; i_fwd_rd = 5'd3; i_fwd_data = 32'hDEADBEEF;
    step();
    chk("t3_fwd_a", o_input_a, 32'hDEADBEEF);
    chk("t3_b", o_input_b, 32'h12);
    chk("t3_valid", {31'd0, o_valid}, 32'd1);
    drive(32'h108, 32'h22, 32'h23, 32'd0, 5'd0, 5'd2, 5'd6, 1'b0, 1'b0, 4'd2);
    i_fwd_rd = 5'd0;
    step();
    chk("t3_x0_a", o_input_a, 32'h22);
    drive(32'h10C, 32'h33, 32'h34, 32'd0, 5'd3, 5'd2, 5'd6, 1'b1, 1'b0, 4'd2);
    i_fwd_we = 1'b0; i_fwd_rd = 5'd3;
    step();
    chk("t3_pc_a", o_input_a, 32'h10C);

    // held entry with rs1_addr==rs2_addr=6, both forwarded during stall
    drive(32'h110, 32'h10, 32'h20, 32'd0, 5'd6, 5'd6, 5'd9, 1'b0, 1'b0, 4'd5);
    step();
    chk("t4_b_pre", o_input_b, 32'h20);
    i_valid = 1'b0; i_ready = 1'b0;
    i_fwd_we = 1'b1; i_fwd_rd = 5'd6; i_fwd_data = 32'h42;
`ifndef ALU_OPSTAGE_SKID_EN
    #1 chk("t4_ready_stall", {31'd0, o_ready}, 32'd0);
`endif
    step();
    i_fwd_we = 1'b0;
    chk("t4_b_fwd", o_input_b, 32'h42);
    chk("t4_a_fwd", o_input_a, 32'h42);
    chk("t4_st_fwd", o_rs2_data, 32'h42);
    chk("t4_valid", {31'd0, o_valid}, 32'd1);
    chk("t4_op", {28'd0, o_alu_op}, 32'd5);
    chk("t4_rd", {27'd0, o_rd_addr}, 32'd9);
    i_ready = 1'b1;
    step();
    chk("t4_drain", {31'd0, o_valid}, 32'd0);

    // flush beats same-cycle capture
    drive(32'h200, 32'h1, 32'h2, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 4'd3);
    step();
    chk("t5_pre", {31'd0, o_valid}, 32'd1);
    drive(32'h204, 32'h5, 32'h6, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 4'd3);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("t5_flush", {31'd0, o_valid}, 32'd0);
    step();
    chk("t5_after", {31'd0, o_valid}, 32'd0);

    // async reset in the middle of a stall
    drive(32'h300, 32'h77, 32'h88, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 4'd4);
    i_ready = 1'b0;
    step();
    i_valid = 1'b0;
    chk("t1_pre", o_input_a, 32'h77);
    i_rst_n = 1'b0;
    #1;
    chk("t1_valid", {31'd0, o_valid}, 32'd0);
    chk("t1_a", o_input_a, 32'd0);
    chk("t1_b", o_input_b, 32'd0);
    chk("t1_ready", {31'd0, o_ready}, 32'd1);
    #1 i_rst_n = 1'b1;
    step();

`ifdef ALU_OPSTAGE_SKID_EN
    i_ready = 1'b0;
    drive(32'h400, 32'hA, 32'd0, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 4'd0);
    step();
    chk("t6_a_out", o_input_a, 32'hA);
    chk("t6_ready_a", {31'd0, o_ready}, 32'd1);
    drive(32'h404, 32'hB, 32'd0, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 4'd0);
    step();
    i_valid = 1'b0;
    chk("t6_hold_a", o_input_a, 32'hA);
    chk("t6_ready_b", {31'd0, o_ready}, 32'd0);
    i_ready = 1'b1;
    step();
    chk("t6_b_out", o_input_a, 32'hB);
    chk("t6_b_vld", {31'd0, o_valid}, 32'd1);
    step();
    chk("t6_empty", {31'd0, o_valid}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
